fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Holds the architectural PC and issues word fetches to the instruction cache.
- Tracks instruction-TLB miss resolution and accepts redirects from decode (jump) and EX/MEM (branch/flush).
- Produces instruction, pcIncr, pcJump and the fetch-exception indication consumed by IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
EXC_VECTOR, 32'h8000_0180, PC loaded after an unrecoverable ITLB miss
NOP_WORD, 32'h0000_0000, instruction emitted when no valid fetch is presented

Ports:
clock  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard stall; holds PC and outputs
redirect_valid  in  1  jump/branch/flush redirect this cycle
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
ic_req  out  1  fetch request, held until completion or cancel
ic_addr  out  32  fetch address (= pc)
ic_ready  in  1  level; ic_rdata valid while high and ic_req held
ic_rdata  in  32  fetched word
itlb_miss  in  1  translation miss for ic_addr
itlb_ready  in  1  TLB walk finished; itlb_miss then final
valid  out  1  outputs hold a fetched instruction or exception
instruction  out  32  fetched word, or NOP_WORD
pcIncr  out  32  address of presented instruction + 4
pcJump  out  32  {pcIncr[31:28], instruction[25:0], 2'b00}
exception  out  1  presented slot is an ITLB fault
faulty_address  out  32  faulting PC when exception=1, else 0

Behaviour:
- Reset values: pc=RESET_PC; state=FETCH; valid=0; instruction=NOP_WORD; pcIncr=0; pcJump=0; exception=0; faulty_address=0; ic_req=0 during the reset cycle.
- All outputs are registered. ic_addr = pc, combinational from the register.
- States:
  - FETCH: ic_req=1.
    - itlb_miss=1 → TLB_WAIT (no completion).
    - Else, when ic_ready && !stall: complete. Latch instruction=ic_rdata, pcIncr=pc+4, pcJump, valid=1, exception=0; pc<=pc+4; stay in FETCH. Latency is 1 cycle from the completing edge.
    - While stall=1: request held, ic_ready ignored, outputs and pc frozen.
  - TLB_WAIT: ic_req=0. Wait for itlb_ready.
    - itlb_ready && !itlb_miss → FETCH (retry same pc).
    - itlb_ready && itlb_miss → EXC.
  - EXC: when !stall, present for one cycle: valid=1, exception=1, faulty_address=pc, instruction=NOP_WORD. Then pc<=EXC_VECTOR → FETCH.
- Redirect (any state) has highest priority over stall, completion and exception:
  - pc<=redirect_pc&~3, state<=FETCH.
  - Outputs cleared next cycle: valid=0, NOP_WORD, exception=0, faulty_address=0.
  - ic_req drops for that cycle, which cancels any outstanding cache request (icache contract).
- When no completion, exception or redirect occurs and stall=0, valid drops to 0 with instruction=NOP_WORD (bubble).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Reset mid-miss or mid-TLB-walk: reset wins; pending cache/TLB activity is abandoned (ic_req=0).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_icache_stall (cycles in FETCH with ic_req && !ic_ready), perf_itlb_wait (cycles in TLB_WAIT) and perf_redirects (count of redirect_valid).
  - All reset to 0 and wrap silently.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {FETCH, TLB_WAIT, EXC}
  - NOP_WORD, RESET_PC, EXC_VECTOR defaults
  - jump-target helper function.
- One natural sub-module: fetch_pc_reg, holding the PC register with next-PC priority mux (reset > redirect > exception vector > increment > hold).

Test Plan:
- Reset release, ic_ready=1 every cycle → ic_addr 0,4,8; valid=1 the cycle after each; pcIncr 4,8,12.
- ic_ready delayed 3 cycles at pc=0x40, rdata 0x0800_0010 → ic_req held 4 cycles; then pcIncr=0x44, pcJump=0x0000_0040.
- stall=1 for 2 cycles with ic_ready=1 → pc and outputs frozen; completion on the first stall=0 edge.
- itlb_miss at pc=0x100, then itlb_ready with miss=1 → exception=1, faulty_address=0x100 for one cycle; next ic_addr=0x8000_0180.
- redirect_valid with redirect_pc=0x203 during an outstanding miss → ic_req low one cycle, valid=0, next ic_addr=0x200; stall asserted simultaneously is overridden.
- pc=0xFFFF_FFFC completes → pcIncr=0, next ic_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, reset/vector defaults and jump-target helper for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    TLB_WAIT = 2'd1,
    EXC      = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
  localparam logic [31:0] DEF_NOP_WORD   = 32'h0000_0000;

  // J-type target: region bits of the sequential PC plus the word index from the instruction
  function automatic logic [31:0] jump_target(input logic [3:0] pc_incr_hi, input logic [25:0] instr_idx);
    return {pc_incr_hi, instr_idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - architectural PC register with next-PC priority mux
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_load,
  input  logic        incr,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC: redirect beats the exception vector, which beats sequential increment, else hold
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (exc_load) begin
      pc_d = EXC_VECTOR;
    end else if (incr) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register; reset has top priority
  always_ff @(posedge clock) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; optional counters under FETCH_PERF_CNT_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD
) (
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_icache_stall,
  output logic [31:0] perf_itlb_wait,
  output logic [31:0] perf_redirects,
`endif
  input  logic        clock,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_rdata,
  input  logic        itlb_miss,
  input  logic        itlb_ready,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pcIncr,
  output logic [31:0] pcJump,
  output logic        exception,
  output logic [31:0] faulty_address
);

  fetch_state_e state_q, state_d;
  logic         ic_req_q, ic_req_d;
  logic         valid_q, valid_d;
  logic [31:0]  instruction_q, instruction_d;
  logic [31:0]  pc_incr_q, pc_incr_d;
  logic [31:0]  pc_jump_q, pc_jump_d;
  logic         exception_q, exception_d;
  logic [31:0]  faulty_address_q, faulty_address_d;

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         complete;
  logic         exc_fire;

  assign pc_plus4 = pc + 32'd4;

  // A fetch completes only on a live request with a good translation and no stall
  assign complete = (state_q == FETCH) && ic_req_q && !itlb_miss && ic_ready && !stall
                    && !redirect_valid;
  assign exc_fire = (state_q == EXC) && !stall && !redirect_valid;

  fetch_pc_reg #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_reg (
    .clock          (clock),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_load       (exc_fire),
    .incr           (complete),
    .pc             (pc)
  );

  // Next state, request and IF/ID output values; redirect overrides everything
  always_comb begin
    state_d          = state_q;
    ic_req_d         = ic_req_q;
    valid_d          = valid_q;
    instruction_d    = instruction_q;
    pc_incr_d        = pc_incr_q;
    pc_jump_d        = pc_jump_q;
    exception_d      = exception_q;
    faulty_address_d = faulty_address_q;

    if (redirect_valid) begin
      state_d          = FETCH;
      ic_req_d         = 1'b0;
      valid_d          = 1'b0;
      instruction_d    = NOP_WORD;
      exception_d      = 1'b0;
      faulty_address_d = 32'd0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!ic_req_q) begin
            // request was dropped by reset or a redirect; reissue at the current pc
            ic_req_d = 1'b1;
          end else if (itlb_miss) begin
            state_d  = TLB_WAIT;
            ic_req_d = 1'b0;
          end else if (complete) begin
            valid_d          = 1'b1;
            instruction_d    = ic_rdata;
            pc_incr_d        = pc_plus4;
            pc_jump_d        = jump_target(pc_plus4[31:28], ic_rdata[25:0]);
            exception_d      = 1'b0;
            faulty_address_d = 32'd0;
          end
        end
        TLB_WAIT: begin
          if (itlb_ready) begin
            if (itlb_miss) begin
              state_d = EXC;
            end else begin
              state_d  = FETCH;
              ic_req_d = 1'b1;
            end
          end
        end
        EXC: begin
          if (exc_fire) begin
            state_d          = FETCH;
            ic_req_d         = 1'b1;
            valid_d          = 1'b1;
            instruction_d    = NOP_WORD;
            exception_d      = 1'b1;
            faulty_address_d = pc;
          end
        end
        default: begin
          state_d  = FETCH;
          ic_req_d = 1'b0;
        end
      endcase

      // Nothing presented and not stalled: emit a bubble
      if (!complete && !exc_fire && !stall) begin
        valid_d          = 1'b0;
        instruction_d    = NOP_WORD;
        exception_d      = 1'b0;
        faulty_address_d = 32'd0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q          <= FETCH;
      ic_req_q         <= 1'b0;
      valid_q          <= 1'b0;
      instruction_q    <= NOP_WORD;
      pc_incr_q        <= 32'd0;
      pc_jump_q        <= 32'd0;
      exception_q      <= 1'b0;
      faulty_address_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      ic_req_q         <= ic_req_d;
      valid_q          <= valid_d;
      instruction_q    <= instruction_d;
      pc_incr_q        <= pc_incr_d;
      pc_jump_q        <= pc_jump_d;
      exception_q      <= exception_d;
      faulty_address_q <= faulty_address_d;
    end
  end

  assign ic_req         = ic_req_q;
  assign ic_addr        = pc;
  assign valid          = valid_q;
  assign instruction    = instruction_q;
  assign pcIncr         = pc_incr_q;
  assign pcJump         = pc_jump_q;
  assign exception      = exception_q;
  assign faulty_address = faulty_address_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_icache_stall_q, perf_icache_stall_d;
  logic [31:0] perf_itlb_wait_q, perf_itlb_wait_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  // Free-running event counters, wrapping silently
  always_comb begin
    perf_icache_stall_d = perf_icache_stall_q;
    perf_itlb_wait_d    = perf_itlb_wait_q;
    perf_redirects_d    = perf_redirects_q;
    if ((state_q == FETCH) && ic_req_q && !ic_ready) begin
      perf_icache_stall_d = perf_icache_stall_q + 32'd1;
    end
    if (state_q == TLB_WAIT) begin
      perf_itlb_wait_d = perf_itlb_wait_q + 32'd1;
    end
    if (redirect_valid) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (rst) begin
      perf_icache_stall_q <= 32'd0;
      perf_itlb_wait_q    <= 32'd0;
      perf_redirects_q    <= 32'd0;
    end else begin
      perf_icache_stall_q <= perf_icache_stall_d;
      perf_itlb_wait_q    <= perf_itlb_wait_d;
      perf_redirects_q    <= perf_redirects_d;
    end
  end

  assign perf_icache_stall = perf_icache_stall_q;
  assign perf_itlb_wait    = perf_itlb_wait_q;
  assign perf_redirects    = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_rdata;
  logic        itlb_miss;
  logic        itlb_ready;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pcIncr;
  logic [31:0] pcJump;
  logic        exception;
  logic [31:0] faulty_address;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_icache_stall;
  logic [31:0] perf_itlb_wait;
  logic [31:0] perf_redirects;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] incr;
    logic [31:0] jump;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] incr;
    logic [31:0] jump;
  } exp_t;

  vec_t vecs[3];
  exp_t sb[$];

  fetch_unit dut (
`ifdef FETCH_PERF_CNT_EN
    .perf_icache_stall (perf_icache_stall),
    .perf_itlb_wait    (perf_itlb_wait),
    .perf_redirects    (perf_redirects),
`endif
    .clock          (clock),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_ready       (ic_ready),
    .ic_rdata       (ic_rdata),
    .itlb_miss      (itlb_miss),
    .itlb_ready     (itlb_ready),
    .valid          (valid),
    .instruction    (instruction),
    .pcIncr         (pcIncr),
    .pcJump         (pcJump),
    .exception      (exception),
    .faulty_address (faulty_address)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] incr, input logic [31:0] jump);
    exp_t e;
    e.instr = instr;
    e.incr  = incr;
    e.jump  = jump;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_sb actual=empty required=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, {31'd0, valid}, 32'd1);
      chk({name, "_instr"}, instruction, e.instr);
      chk({name, "_incr"}, pcIncr, e.incr);
      chk({name, "_jump"}, pcJump, e.jump);
      chk({name, "_exc"}, {31'd0, exception}, 32'd0);
    end
  endtask

  task automatic do_redirect(input string name, input logic [31:0] target, input logic [31:0] exp_pc);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    chk({name, "_req_drop"}, {31'd0, ic_req}, 32'd0);
    chk({name, "_valid_clr"}, {31'd0, valid}, 32'd0);
    chk({name, "_instr_nop"}, instruction, 32'h0000_0000);
    chk({name, "_addr"}, ic_addr, exp_pc);
    stall = 1'b0;
    step();
    chk({name, "_req_back"}, {31'd0, ic_req}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{rdata: 32'h0000_0003, addr: 32'h0000_0000, incr: 32'h0000_0004, jump: 32'h0000_000C};
    vecs[1] = '{rdata: 32'h03FF_FFFF, addr: 32'h0000_0004, incr: 32'h0000_0008, jump: 32'h0FFF_FFFC};
    vecs[2] = '{rdata: 32'hAC00_0010, addr: 32'h0000_0008, incr: 32'h0000_000C, jump: 32'h0000_0040};

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ic_ready = 1'b0; ic_rdata = '0; itlb_miss = 1'b0; itlb_ready = 1'b0;
    step();
    step();

    // reset state
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0000_0000);
    chk("rst_incr", pcIncr, 32'd0);
    chk("rst_jump", pcJump, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_fault", faulty_address, 32'd0);
    chk("rst_req", {31'd0, ic_req}, 32'd0);
    chk("rst_addr", ic_addr, 32'h0000_0000);

    rst = 1'b0;
    step();
    chk("rel_req", {31'd0, ic_req}, 32'd1);

    // back-to-back fetches with ic_ready every cycle
    for (int i = 0; i < 3; i++) begin
      ic_ready = 1'b1;
      ic_rdata = vecs[i].rdata;
      chk($sformatf("seq%0d_req", i), {31'd0, ic_req}, 32'd1);
      chk($sformatf("seq%0d_addr", i), ic_addr, vecs[i].addr);
      push_exp(vecs[i].rdata, vecs[i].incr, vecs[i].jump);
      step();
      pop_chk($sformatf("seq%0d", i));
    end
    ic_ready = 1'b0;

    // delayed ic_ready at 0x40
    do_redirect("rd40", 32'h0000_0040, 32'h0000_0040);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait%0d_req", i), {31'd0, ic_req}, 32'd1);
      chk($sformatf("wait%0d_addr", i), ic_addr, 32'h0000_0040);
      step();
      chk($sformatf("wait%0d_valid", i), {31'd0, valid}, 32'd0);
    end
    chk("wait3_req", {31'd0, ic_req}, 32'd1);
    ic_ready = 1'b1;
    ic_rdata = 32'h0800_0010;
    push_exp(32'h0800_0010, 32'h0000_0044, 32'h0000_0040);
    step();
    pop_chk("late");

    // stall with ic_ready high freezes pc and outputs
    stall    = 1'b1;
    ic_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("stall%0d_addr", i), ic_addr, 32'h0000_0044);
      chk($sformatf("stall%0d_valid", i), {31'd0, valid}, 32'd1);
      chk($sformatf("stall%0d_incr", i), pcIncr, 32'h0000_0044);
      chk($sformatf("stall%0d_req", i), {31'd0, ic_req}, 32'd1);
    end
    stall = 1'b0;
    push_exp(32'h1234_5678, 32'h0000_0048, 32'h08D1_59E0);
    step();
    pop_chk("unstall");
    ic_ready = 1'b0;

    // unrecoverable ITLB miss at 0x100
    do_redirect("rd100", 32'h0000_0100, 32'h0000_0100);
    itlb_miss = 1'b1;
    step();
    chk("tlb_req_low", {31'd0, ic_req}, 32'd0);
    step();
    chk("tlb_wait_req", {31'd0, ic_req}, 32'd0);
    chk("tlb_wait_valid", {31'd0, valid}, 32'd0);
    itlb_ready = 1'b1;
    step();
    itlb_ready = 1'b0;
    itlb_miss  = 1'b0;
    step();
    chk("exc_valid", {31'd0, valid}, 32'd1);
    chk("exc_flag", {31'd0, exception}, 32'd1);
    chk("exc_fault", faulty_address, 32'h0000_0100);
    chk("exc_instr", instruction, 32'h0000_0000);
    chk("exc_vector", ic_addr, 32'h8000_0180);
    step();
    chk("exc_once_flag", {31'd0, exception}, 32'd0);
    chk("exc_once_fault", faulty_address, 32'd0);
    chk("exc_once_valid", {31'd0, valid}, 32'd0);

    // recoverable ITLB miss retries the same pc
    itlb_miss = 1'b1;
    step();
    chk("retry_req_low", {31'd0, ic_req}, 32'd0);
    itlb_ready = 1'b1;
    itlb_miss  = 1'b0;
    step();
    itlb_ready = 1'b0;
    chk("retry_req", {31'd0, ic_req}, 32'd1);
    chk("retry_addr", ic_addr, 32'h8000_0180);
    chk("retry_exc", {31'd0, exception}, 32'd0);

    // complete, then hold under stall with an outstanding miss, then redirect overrides stall
    ic_ready = 1'b1;
    ic_rdata = 32'h0C00_0001;
    push_exp(32'h0C00_0001, 32'h8000_0184, 32'h8000_0004);
    step();
    pop_chk("vec_fetch");
    ic_ready = 1'b0;
    stall    = 1'b1;
    step();
    chk("hold_valid", {31'd0, valid}, 32'd1);
    chk("hold_addr", ic_addr, 32'h8000_0184);
    do_redirect("rd203", 32'h0000_0203, 32'h0000_0200);

    // pc wrap at the top of the address space
    do_redirect("rdtop", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    ic_ready = 1'b1;
    ic_rdata = 32'h0000_0020;
    push_exp(32'h0000_0020, 32'h0000_0000, 32'h0000_0080);
    step();
    pop_chk("wrap");
    chk("wrap_addr", ic_addr, 32'h0000_0000);
    ic_ready = 1'b0;

    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
